alu_muldiv_unit: RTL and testbench

Iterative RV64M multiply/divide unit paired with the ALU datapath. It decodes inst_funct3 and the OP-32 flag, in the same way the ALU control decodes funct3/bit30, into one of 13 M-extension operations. Each operation runs through a shift-add or restoring-division datapath. It takes XLEN-parametrised operands, uses a start/ready/valid handshake, supports pipeline flush (kill), and provides a single-cycle fast path for the special cases.

---
 rtl/alu_muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier, restoring divider,
// single-cycle fast path for divide-by-zero, signed overflow and reserved W forms.
module alu_muldiv_unit #(
  parameter int XLEN            = 64,
  parameter int ENABLE_WORD_OPS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            ready,
  input  logic            kill,
  input  logic [2:0]      inst_funct3,
  input  logic            inst_word,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] result,
  output logic            valid_out
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic              valid_r;
  logic [2:0]        op_r;
  logic              word_r, neg_q_r, neg_r_r;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand, acc_nx;
  logic [XLEN-1:0]   opb;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  logic            word_in, is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic            b_zero, a_min, b_m1, ovf, rsvd, fast;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, a_res, fast_res;

  always_comb begin
    word_in   = inst_word & (ENABLE_WORD_OPS != 0);
    is_div_in = inst_funct3[2];
    sgn_a_in  = !(inst_funct3 inside {3'b011, 3'b101, 3'b111});
    sgn_b_in  = sgn_a_in && (inst_funct3 != 3'b010);
    a_ext     = operand_a;
    b_ext     = operand_b;
    if (word_in) begin
      a_ext = sgn_a_in ? sext32(operand_a[31:0]) : XLEN'(operand_a[31:0]);
      b_ext = sgn_b_in ? sext32(operand_b[31:0]) : XLEN'(operand_b[31:0]);
    end
    neg_a_in = sgn_a_in & a_ext[XLEN-1];
    neg_b_in = sgn_b_in & b_ext[XLEN-1];
    mag_a    = neg_a_in ? -a_ext : a_ext;
    mag_b    = neg_b_in ? -b_ext : b_ext;
    b_zero   = (b_ext == '0);
    a_min    = word_in ? (operand_a[31:0] == 32'h8000_0000)
                       : (operand_a == {1'b1, {(XLEN-1){1'b0}}});
    b_m1     = word_in ? (&operand_b[31:0]) : (&operand_b);
    ovf      = is_div_in & sgn_a_in & a_min & b_m1;
    rsvd     = word_in & ~is_div_in & (inst_funct3[1:0] != 2'b00);
    fast     = rsvd | (is_div_in & (b_zero | ovf));
    a_res    = word_in ? sext32(operand_a[31:0]) : operand_a;
    fast_res = '0;
    if (!rsvd) begin
      if (b_zero) fast_res = inst_funct3[1] ? a_res : '1;
      else        fast_res = inst_funct3[1] ? '0 : a_res;
    end
  end

  // One iteration per cycle; the final iteration feeds calc_res directly.
  logic [XLEN:0]     rem_sh, trial;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s, r_s, calc_res;

  always_comb begin
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    trial  = rem_sh - {1'b0, opb};
    if (op_r[2])
      acc_nx = trial[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nx = opb[0] ? acc + mcand : acc;
    prod_s = neg_q_r ? -acc_nx : acc_nx;
    q_s    = neg_q_r ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    r_s    = neg_r_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    case (op_r)
      3'b000:                 calc_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = q_s;
      default:                calc_res = r_s;
    endcase
    if (word_r) calc_res = sext32(calc_res[31:0]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      valid_r <= 1'b0;
      result  <= '0;
      op_r    <= '0;
      word_r  <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      opb     <= '0;
    end else if (kill) begin
      state   <= IDLE;
      ready   <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_r <= 1'b0;
          if (start) begin
            op_r    <= inst_funct3;
            word_r  <= word_in;
            neg_q_r <= neg_a_in ^ neg_b_in;
            neg_r_r <= neg_a_in;
            mcand   <= {{XLEN{1'b0}}, mag_a};
            opb     <= mag_b;
            cnt     <= word_in ? CW'(32) : CW'(XLEN);
            ready   <= 1'b0;
            // Word divides start with the dividend left-aligned so 32 shifts suffice.
            if (is_div_in)
              acc <= {{XLEN{1'b0}}, (word_in ? mag_a << (XLEN - 32) : mag_a)};
            else
              acc <= '0;
            if (fast) begin
              state   <= DONE;
              valid_r <= 1'b1;
              result  <= fast_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_nx;
          mcand <= mcand << 1;
          if (!op_r[2]) opb <= opb >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= DONE;
            valid_r <= 1'b1;
            result  <= calc_res;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready   <= 1'b1;
          valid_r <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign valid_out = valid_r & ~kill;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit: directed vector table, abort/reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_alu_muldiv_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic        inst_word = 1'b0;
  logic [2:0]  inst_funct3 = 3'd0;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic        ready, valid_out;
  logic [63:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res = '0;

  always #5 clock = ~clock;

  alu_muldiv_unit #(.XLEN(64), .ENABLE_WORD_OPS(1)) dut (
    .clock(clock), .reset(reset), .start(start), .ready(ready), .kill(kill),
    .inst_funct3(inst_funct3), .inst_word(inst_word),
    .operand_a(operand_a), .operand_b(operand_b),
    .result(result), .valid_out(valid_out)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb;
    logic [127:0]        ua, ub, p;
    logic [31:0]         a32, b32, t;
    logic signed [31:0]  a32s, b32s;
    longint              sa64, sb64;
    logic [63:0]         r;
    a32 = a[31:0]; b32 = b[31:0]; a32s = a32; b32s = b32;
    sa64 = a; sb64 = b;
    if (w) begin
      case (f3)
        3'd0: begin t = a32 * b32; return sx(t); end
        3'd4: begin
          if (b32 == 0) return '1;
          if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx(a32);
          t = a32s / b32s; return sx(t);
        end
        3'd5: begin if (b32 == 0) return '1; t = a32 / b32; return sx(t); end
        3'd6: begin
          if (b32 == 0) return sx(a32);
          if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return '0;
          t = a32s % b32s; return sx(t);
        end
        3'd7: begin if (b32 == 0) return sx(a32); t = a32 % b32; return sx(t); end
        default: return '0;
      endcase
    end
    case (f3)
      3'd0: begin r = a * b; return r; end
      3'd1: begin sa = $signed(a); sb = $signed(b); p = sa * sb; return p[127:64]; end
      3'd2: begin sa = $signed(a); sb = {64'd0, b}; p = sa * sb; return p[127:64]; end
      3'd3: begin ua = {64'd0, a}; ub = {64'd0, b}; p = ua * ub; return p[127:64]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        r = sa64 / sb64; return r;
      end
      3'd5: begin if (b == 0) return '1; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
        r = sa64 % sb64; return r;
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    logic bz, of;
    if (w && f3 inside {3'd1, 3'd2, 3'd3}) return 1;
    bz = w ? (b[31:0] == 0) : (b == 0);
    of = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
           : (a == 64'h8000_0000_0000_0000 && b == '1);
    if (f3[2] && bz) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && of) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(5, 0))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(20, 0));
      4: return {$urandom, ($urandom_range(1, 0) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic wait_valid(input int k0, output int k);
    k = k0;
    while (!valid_out && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    inst_funct3 = f3; inst_word = w; operand_a = a; operand_b = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic apply(input string name, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    int k;
    check({name, "_ready_idle"}, 64'(ready), 64'd1);
    issue(f3, w, a, b);
    check({name, "_ready_busy"}, 64'(ready), 64'd0);
    wait_valid(1, k);
    check({name, "_latency"}, 64'(k), 64'(lat));
    check({name, "_result"}, result, exp);
    last_res = exp;
    @(posedge clock); #1;
    check({name, "_pulse"}, 64'(valid_out), 64'd0);
    check({name, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int          k;
    logic        seen;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;

    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{3'd2, 1'b0, '1, 64'd2, '1, 65};
    vecs[3]  = '{3'd4, 1'b0, 64'd100, 64'd0, '1, 1};
    vecs[4]  = '{3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1};
    vecs[5]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vecs[6]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    vecs[7]  = '{3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[8]  = '{3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, '1, 33};
    vecs[9]  = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[10] = '{3'd1, 1'b1, 64'd5, 64'd6, 64'd0, 1};
    vecs[11] = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};
    vecs[12] = '{3'd5, 1'b1, 64'hAAAA_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, '1, 1};
    vecs[13] = '{3'd7, 1'b1, 64'hAAAA_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[14] = '{3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};

    #1 reset = 1'b0;
    #10;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 15; i++)
      apply($sformatf("vec%0d", i), vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat);

    // start during CALC must be dropped, not queued
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (4) begin @(posedge clock); #1; end
    check("calc_start_ready", 64'(ready), 64'd0);
    inst_funct3 = 3'd4; inst_word = 1'b0; operand_a = 64'd100; operand_b = 64'd0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_valid(6, k);
    check("calc_start_latency", 64'(k), 64'd65);
    check("calc_start_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    last_res = 64'hFFFF_FFFF_FFFF_FFEB;
    seen = 1'b0;
    repeat (6) begin @(posedge clock); #1; if (valid_out) seen = 1'b1; end
    check("calc_start_no_extra", 64'(seen), 64'd0);

    // kill at iteration 10
    issue(3'd5, 1'b0, 64'd1000, 64'd7);
    repeat (9) begin @(posedge clock); #1; end
    check("kill_busy", 64'(ready), 64'd0);
    kill = 1'b1;
    #1 check("kill_valid_low", 64'(valid_out), 64'd0);
    @(posedge clock); #1;
    kill = 1'b0;
    check("kill_ready", 64'(ready), 64'd1);
    seen = 1'b0;
    repeat (70) begin @(posedge clock); #1; if (valid_out) seen = 1'b1; end
    check("kill_no_valid", 64'(seen), 64'd0);
    check("kill_result_held", result, last_res);

    // kill together with start in IDLE: not accepted
    inst_funct3 = 3'd4; operand_a = 64'd1; operand_b = 64'd0;
    start = 1'b1; kill = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_ready", 64'(ready), 64'd1);
    check("kill_start_valid", 64'(valid_out), 64'd0);

    // asynchronous reset at iteration 20
    issue(3'd3, 1'b0, '1, '1);
    repeat (19) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_valid", 64'(valid_out), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd1);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    apply("divu_after_reset", 3'd5, 1'b0, 64'd9, 64'd4, 64'd2, 65);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(7, 0));
      w  = 1'($urandom_range(1, 0));
      a  = pick();
      b  = pick();
      apply($sformatf("rnd%0d_f%0d_w%0d", i, f3, w), f3, w, a, b,
            model(f3, w, a, b), model_lat(f3, w, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
